// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: round-robin packet-locked arbiter merging N_REQ AXI-Stream inputs onto one registered output
module stream_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int DATA_W = 8,
  parameter bit LOCK_PKT = 1,
  parameter int ID_W = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ*DATA_W-1:0] s_tdata,
  input  logic [N_REQ-1:0]        s_tvalid,
  input  logic [N_REQ-1:0]        s_tlast,
  output logic [N_REQ-1:0]        s_tready,
  output logic [DATA_W-1:0]       m_tdata,
  output logic                    m_tvalid,
  output logic                    m_tlast,
  output logic [ID_W-1:0]         m_tid,
  input  logic                    m_tready,
  output logic                    busy
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nxt;
  logic [ID_W-1:0] grant, last_grant, pick, idx;
  logic found, rdy, accept, done;
  always_comb begin
    pick = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ID_W'((int'(last_grant) + k) % N_REQ);
      if (!found && s_tvalid[idx]) begin
        pick = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    rdy = state == GRANT && (!m_tvalid || m_tready);
    s_tready = rdy ? (N_REQ'(1) << grant) : '0;
    accept = rdy && s_tvalid[grant];
    done = accept && (!LOCK_PKT || s_tlast[grant]);
    state_nxt = state == IDLE ? (found ? GRANT : IDLE) : (done ? IDLE : GRANT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= ID_W'(N_REQ - 1);
      m_tdata <= '0;
      m_tvalid <= 1'b0;
      m_tlast <= 1'b0;
      m_tid <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && found) grant <= pick;
      if (done) last_grant <= grant;
      if (accept) begin
        m_tdata <= s_tdata[int'(grant) * DATA_W +: DATA_W];
        m_tlast <= s_tlast[grant];
        m_tid <= grant;
        m_tvalid <= 1'b1;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
    end
  end
  assign busy = state == GRANT || m_tvalid;
endmodule
